signed_decimal_display: RTL

Sequential, parametrised signed-binary to multi-digit seven-segment converter for the board's display path. It generalises the fixed two-digit signed display to WIDTH-bit operands and DIGITS decimal digits. Conversion uses an iterative double-dabble (shift-and-add-3) engine rather than combinational divide/modulo, and it adds a start/done handshake, leading-zero blanking and overflow indication. Results are held in registers, so the display stays stable while the next conversion runs.

---
 rtl/signed_decimal_display_pkg.sv | 16 +
 rtl/signed_decimal_display_if.sv | 23 ++
 rtl/seven_segment.sv | 22 ++
 rtl/signed_decimal_display_bcd_shift_step.sv | 19 +
 rtl/signed_decimal_display.sv | 114 +++++++++++
 5 files changed

// File: rtl/signed_decimal_display_pkg.sv
// Shared constants for the signed decimal display path: segment patterns and FSM encoding.
// Segments are active-high, bit order {g,f,e,d,c,b,a}.
package signed_decimal_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_MINUS = 7'h40;
    // Overflow marker: top, middle and bottom bars, distinct from the minus sign.
    localparam logic [6:0] SEG_DASH  = 7'h49;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/signed_decimal_display_if.sv
// Request/result bundle between a display client and signed_decimal_display.
interface signed_decimal_display_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      val;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    logic [6:0]            seg7_neg_sign;
    logic [7*DIGITS-1:0]   seg7_digits;

    modport master (
        output start, val,
        input  busy, done, overflow, seg7_neg_sign, seg7_digits
    );

    modport slave (
        input  start, val,
        output busy, done, overflow, seg7_neg_sign, seg7_digits
    );
endinterface

// File: rtl/seven_segment.sv
// 4-bit BCD digit to active-high seven-segment pattern {g,f,e,d,c,b,a}; non-decimal codes blank.
module seven_segment (
    input  logic [3:0] digit,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'h00;
        case (digit)
            4'd0: seg = 7'h3F;
            4'd1: seg = 7'h06;
            4'd2: seg = 7'h5B;
            4'd3: seg = 7'h4F;
            4'd4: seg = 7'h66;
            4'd5: seg = 7'h6D;
            4'd6: seg = 7'h7D;
            4'd7: seg = 7'h07;
            4'd8: seg = 7'h7F;
            4'd9: seg = 7'h6F;
            default: seg = 7'h00;
        endcase
    end
endmodule

// File: rtl/signed_decimal_display_bcd_shift_step.sv
// One double-dabble iteration: add 3 to every nibble >= 5, then shift left pulling in bit_in.
module bcd_shift_step #(
    parameter int DIGITS = 3
) (
    input  logic [4*DIGITS-1:0] bcd_in,
    input  logic                bit_in,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                carry_out
);
    logic [4*DIGITS-1:0] adj;

    for (genvar g = 0; g < DIGITS; g++) begin : g_nib
        assign adj[4*g +: 4] = (bcd_in[4*g +: 4] >= 4'd5) ? bcd_in[4*g +: 4] + 4'd3
                                                         : bcd_in[4*g +: 4];
    end

    // The bit pushed out of the top nibble means the value no longer fits in DIGITS digits.
    assign {carry_out, bcd_out} = {adj, bit_in};
endmodule

// File: rtl/signed_decimal_display.sv
// Sequential signed binary to DIGITS-digit seven-segment converter using an iterative
// double-dabble engine; results are held in display registers while the next one runs.
module signed_decimal_display
    import signed_decimal_display_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int DIGITS        = 3,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    signed_decimal_display_if.slave  dbus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt;
    logic [WIDTH-1:0]    mag;
    logic [BW-1:0]       bcd, bcd_step;
    logic                carry, ovf_acc, sign_w;
    logic                disp_sign, disp_ovf, done_r;
    logic [BW-1:0]       disp_bcd;
    logic [DIGITS-1:0][6:0] seg_raw, seg_out;

    bcd_shift_step #(.DIGITS(DIGITS)) u_step (
        .bcd_in    (bcd),
        .bit_in    (mag[WIDTH-1]),
        .bcd_out   (bcd_step),
        .carry_out (carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (dbus.start) state_nxt = SHIFT;
            SHIFT:   if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            mag       <= '0;
            bcd       <= '0;
            ovf_acc   <= 1'b0;
            sign_w    <= 1'b0;
            disp_sign <= 1'b0;
            disp_ovf  <= 1'b0;
            disp_bcd  <= '0;
            done_r    <= 1'b0;
        end else begin
            done_r <= (state == DONE);
            case (state)
                IDLE: if (dbus.start) begin
                    sign_w  <= dbus.val[WIDTH-1];
                    // Unsigned WIDTH-bit magnitude keeps -2^(WIDTH-1) exact.
                    mag     <= dbus.val[WIDTH-1] ? (~dbus.val + 1'b1) : dbus.val;
                    bcd     <= '0;
                    cnt     <= '0;
                    ovf_acc <= 1'b0;
                end
                SHIFT: begin
                    bcd <= bcd_step;
                    mag <= {mag[WIDTH-2:0], 1'b0};
                    cnt <= cnt + 1'b1;
                    if (carry) ovf_acc <= 1'b1;
                end
                DONE: begin
                    disp_sign <= sign_w;
                    disp_bcd  <= bcd;
                    disp_ovf  <= ovf_acc;
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        seven_segment u_seg (
            .digit (disp_bcd[4*g +: 4]),
            .seg   (seg_raw[g])
        );
    end

    // lz[i]: digits i and above are all zero, so digit i is a leading zero.
    always_comb begin
        logic [DIGITS:0] lz;
        lz = '0;
        lz[DIGITS] = 1'b1;
        seg_out = '0;
        for (int i = DIGITS - 1; i >= 0; i--)
            lz[i] = lz[i+1] && (disp_bcd[4*i +: 4] == 4'd0);
        for (int i = 0; i < DIGITS; i++) begin
            if (disp_ovf)                           seg_out[i] = SEG_DASH;
            else if (BLANK_LEADING && i > 0 && lz[i]) seg_out[i] = SEG_BLANK;
            else                                    seg_out[i] = seg_raw[i];
        end
    end

    assign dbus.busy          = (state != IDLE);
    assign dbus.done          = done_r;
    assign dbus.overflow      = disp_ovf;
    assign dbus.seg7_neg_sign = disp_sign ? SEG_MINUS : SEG_BLANK;
    assign dbus.seg7_digits   = seg_out;
endmodule
